servo_cycle_sequencer: RTL and testbench

- Per-axis control-period sequencer sitting between the CPU register interface and one three-phase PWM generator and its QEI decoder.
- Runs a fixed control period. At each period start it pulses the QEI position latch, then raises a CPU interrupt after a sample delay.
- Accepts shadow duty writes plus a commit, and applies committed duties atomically at the next period boundary.
- Counts consecutive missed commits and forces all duties to zero in a latched fault state after too many misses.

---
 rtl/servo_cycle_sequencer_if.sv | 28 ++
 rtl/servo_cycle_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_servo_cycle_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_cycle_sequencer_if.sv
// CPU-side register bus and PWM/QEI-side outputs of one servo axis sequencer.
// wr_en is a single-cycle strobe with no back-pressure: every cycle with wr_en=1 is one accepted write.
interface servo_cycle_sequencer_if #(
  parameter int DUTY_W = 12
);
  logic              enable;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [DUTY_W-1:0] wr_data;
  logic [DUTY_W-1:0] duty_a;
  logic [DUTY_W-1:0] duty_b;
  logic [DUTY_W-1:0] duty_c;
  logic              duty_update;
  logic              qei_latch;
  logic              irq;
  logic              fault;
  logic [3:0]        miss_count;

  modport master (
    output enable, wr_en, wr_addr, wr_data,
    input  duty_a, duty_b, duty_c, duty_update, qei_latch, irq, fault, miss_count
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data,
    output duty_a, duty_b, duty_c, duty_update, qei_latch, irq, fault, miss_count
  );
endinterface

// File: rtl/servo_cycle_sequencer.sv
// Control-period sequencer: QEI latch at each period start, sample irq, atomic duty
// commit at period boundaries, and a latched fault after too many missed commits.
module servo_cycle_sequencer #(
  parameter int DUTY_W        = 12,
  parameter int PERIOD_CYCLES = 2500,
  parameter int SAMPLE_DELAY  = 50,
  parameter int DUTY_MAX      = 2000,
  parameter int MAX_MISSED    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  servo_cycle_sequencer_if.slave bus,
  output logic [1:0]             o_dbg_state
);
  localparam int CNT_W = $clog2(PERIOD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                  r_state, w_state_n;
  logic [CNT_W-1:0]        r_cnt, w_cnt_n;
  logic [2:0][DUTY_W-1:0]  r_shadow, w_shadow_n;
  logic [2:0][DUTY_W-1:0]  r_duty, w_duty_n;
  logic                    r_pending, w_pending_n;
  logic                    r_irq, w_irq_n;
  logic                    r_update, w_update_n;
  logic                    r_qei, w_qei_n;
  logic                    r_fault, w_fault_n;
  logic [3:0]              r_miss, w_miss_n;

  logic                    w_boundary;
  logic                    w_commit;
  logic                    w_clear;
  logic [3:0]              w_miss_inc;
  logic [DUTY_W-1:0]       w_clamped;

  assign w_boundary = (r_state == S_RUN) && (r_cnt == '0);
  assign w_commit   = bus.wr_en && (bus.wr_addr == 2'd3) && bus.wr_data[0];
  assign w_clear    = bus.wr_en && (bus.wr_addr == 2'd3) && bus.wr_data[1];
  assign w_miss_inc = r_miss + 4'd1;
  assign w_clamped  = (bus.wr_data > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : bus.wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_shadow_n  = r_shadow;
    w_duty_n    = r_duty;
    w_pending_n = r_pending;
    w_irq_n     = r_irq;
    w_miss_n    = r_miss;
    w_fault_n   = r_fault;
    w_update_n  = 1'b0;
    w_qei_n     = 1'b0;

    // Shadows load in any state; the boundary copy below reads r_shadow, so a
    // write landing in the boundary cycle waits for the next period.
    if (bus.wr_en) begin
      case (bus.wr_addr)
        2'd0:    w_shadow_n[0] = w_clamped;
        2'd1:    w_shadow_n[1] = w_clamped;
        2'd2:    w_shadow_n[2] = w_clamped;
        default: w_shadow_n    = r_shadow;
      endcase
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_n     = '0;
        w_duty_n    = '0;
        w_irq_n     = 1'b0;
        w_pending_n = 1'b0;
        w_miss_n    = 4'd0;
        w_fault_n   = 1'b0;
        if (bus.enable) begin
          w_state_n = S_RUN;
          w_qei_n   = 1'b1;
        end
      end

      S_RUN: begin
        w_fault_n = 1'b0;
        if (!bus.enable) begin
          w_state_n   = S_IDLE;
          w_cnt_n     = '0;
          w_duty_n    = '0;
          w_irq_n     = 1'b0;
          w_pending_n = 1'b0;
          w_miss_n    = 4'd0;
        end else begin
          w_cnt_n = (r_cnt == CNT_W'(PERIOD_CYCLES - 1)) ? '0 : r_cnt + CNT_W'(1);
          w_qei_n = (w_cnt_n == '0);
          if (w_boundary) begin
            if (r_pending) begin
              w_duty_n    = r_shadow;
              w_update_n  = 1'b1;
              w_pending_n = 1'b0;
              w_miss_n    = 4'd0;
            end else if (r_irq) begin
              w_miss_n = w_miss_inc;
            end
          end
          if (w_commit) begin
            w_pending_n = 1'b1;
          end
          // The sample-point set outranks a commit clear landing on the same edge.
          if (w_cnt_n == CNT_W'(SAMPLE_DELAY)) begin
            w_irq_n = 1'b1;
          end else if (w_commit || w_boundary) begin
            w_irq_n = 1'b0;
          end
          if (w_boundary && !r_pending && r_irq && (w_miss_inc == 4'(MAX_MISSED))) begin
            w_state_n   = S_FAULT;
            w_cnt_n     = '0;
            w_qei_n     = 1'b0;
            w_duty_n    = '0;
            w_irq_n     = 1'b0;
            w_pending_n = 1'b0;
            w_fault_n   = 1'b1;
          end
        end
      end

      S_FAULT: begin
        w_cnt_n     = '0;
        w_duty_n    = '0;
        w_irq_n     = 1'b0;
        w_pending_n = 1'b0;
        w_fault_n   = 1'b1;
        if (w_clear) begin
          w_fault_n = 1'b0;
          w_miss_n  = 4'd0;
          w_state_n = bus.enable ? S_RUN : S_IDLE;
          w_qei_n   = bus.enable;
        end
      end

      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow  <= '0;
      r_duty    <= '0;
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
      r_update  <= 1'b0;
      r_qei     <= 1'b0;
      r_fault   <= 1'b0;
      r_miss    <= 4'd0;
    end else begin
      r_shadow  <= w_shadow_n;
      r_duty    <= w_duty_n;
      r_pending <= w_pending_n;
      r_irq     <= w_irq_n;
      r_update  <= w_update_n;
      r_qei     <= w_qei_n;
      r_fault   <= w_fault_n;
      r_miss    <= w_miss_n;
    end
  end

  assign bus.duty_a      = r_duty[0];
  assign bus.duty_b      = r_duty[1];
  assign bus.duty_c      = r_duty[2];
  assign bus.duty_update = r_update;
  assign bus.qei_latch   = r_qei;
  assign bus.irq         = r_irq;
  assign bus.fault       = r_fault;
  assign bus.miss_count  = r_miss;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_servo_cycle_sequencer.sv
// Bench for servo_cycle_sequencer: directed timeline from the test plan plus random
// register traffic, all checked every cycle against a behavioural period model.
module tb_servo_cycle_sequencer;
  localparam int DUTY_W = 12;
  localparam int P      = 100;
  localparam int SD     = 10;
  localparam int DMAX   = 2000;
  localparam int MAXM   = 3;
  localparam int VW     = 3 * DUTY_W + 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  servo_cycle_sequencer_if #(.DUTY_W(DUTY_W)) bus ();

  servo_cycle_sequencer #(
    .DUTY_W(DUTY_W), .PERIOD_CYCLES(P), .SAMPLE_DELAY(SD),
    .DUTY_MAX(DMAX), .MAX_MISSED(MAXM)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- behavioural model + scoreboard ----------------
  logic [VW-1:0]     exp_q[$];
  int                m_mode;   // 0 idle, 1 run, 2 fault
  int                m_t;      // cycles since entering run
  logic [DUTY_W-1:0] m_sh[3];
  logic [DUTY_W-1:0] m_duty[3];
  bit                m_pend, m_irq, m_upd;
  int                m_miss;

  function automatic logic [VW-1:0] model_vec();
    logic qei;
    qei = (m_mode == 1) && ((m_t % P) == 0);
    return {m_duty[0], m_duty[1], m_duty[2], m_upd, qei, m_irq, (m_mode == 2), 4'(m_miss)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_pend = 0; m_irq = 0; m_upd = 0; m_miss = 0;
    for (int i = 0; i < 3; i++) begin m_sh[i] = '0; m_duty[i] = '0; end
    exp_q.delete();
    exp_q.push_back(model_vec());
  endtask

  task automatic model_step();
    bit commit, clr, trip;
    int c;
    commit = bus.wr_en && (bus.wr_addr == 2'd3) && bus.wr_data[0];
    clr    = bus.wr_en && (bus.wr_addr == 2'd3) && bus.wr_data[1];
    m_upd  = 0;
    case (m_mode)
      0: if (bus.enable) begin m_mode = 1; m_t = 0; end
      1: begin
        if (!bus.enable) begin
          m_mode = 0; m_irq = 0; m_pend = 0; m_miss = 0;
          for (int i = 0; i < 3; i++) m_duty[i] = '0;
        end else begin
          c = m_t % P;
          trip = 0;
          if (c == 0 && m_pend) begin
            m_duty = m_sh; m_upd = 1; m_pend = 0; m_miss = 0;
          end else if (c == 0 && m_irq) begin
            m_miss++;
            trip = (m_miss == MAXM);
          end
          if (trip) begin
            m_mode = 2; m_irq = 0; m_pend = 0;
            for (int i = 0; i < 3; i++) m_duty[i] = '0;
          end else begin
            m_t++;
            if (commit) m_pend = 1;
            if ((m_t % P) == SD) m_irq = 1;
            else if (commit || c == 0) m_irq = 0;
          end
        end
      end
      default: if (clr) begin m_miss = 0; m_mode = bus.enable ? 1 : 0; m_t = 0; end
    endcase
    if (bus.wr_en && bus.wr_addr != 2'd3)
      m_sh[bus.wr_addr] = (bus.wr_data > DMAX) ? DUTY_W'(DMAX) : bus.wr_data;
    exp_q.push_back(model_vec());
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  initial forever begin
    logic [VW-1:0] e, a;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.duty_a, bus.duty_b, bus.duty_c, bus.duty_update, bus.qei_latch,
           bus.irq, bus.fault, bus.miss_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual a=%0d b=%0d c=%0d upd=%0b qei=%0b irq=%0b fault=%0b miss=%0d required a=%0d b=%0d c=%0d upd=%0b qei=%0b irq=%0b fault=%0b miss=%0d",
                 $time, a[VW-1 -: DUTY_W], a[VW-1-DUTY_W -: DUTY_W], a[VW-1-2*DUTY_W -: DUTY_W],
                 a[7], a[6], a[5], a[4], a[3:0],
                 e[VW-1 -: DUTY_W], e[VW-1-DUTY_W -: DUTY_W], e[VW-1-2*DUTY_W -: DUTY_W],
                 e[7], e[6], e[5], e[4], e[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto_cyc(input int k);
    while (cyc < k) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [DUTY_W-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = '0;
  endtask

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog time limit expired at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int upd_seen;
    logic [DUTY_W-1:0] d;
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_duty_a", bus.duty_a, 0);
    chk("reset_irq", bus.irq, 0);
    chk("reset_qei", bus.qei_latch, 0);
    chk("reset_fault", bus.fault, 0);

    bus.enable = 1'b1;
    @(negedge clk); cyc = 0;
    chk("c0_qei", bus.qei_latch, 1);
    chk("c0_no_update", bus.duty_update, 0);
    step(); chk("c1_qei", bus.qei_latch, 0);
    goto_cyc(9);  chk("c9_irq", bus.irq, 0);
    goto_cyc(10); chk("c10_irq", bus.irq, 1);
    goto_cyc(20);
    wr(2'd0, 12'd500); wr(2'd1, 12'd2500); wr(2'd2, 12'd0);
    goto_cyc(40); chk("c40_irq", bus.irq, 1);
    wr(2'd3, 12'd1); chk("c41_irq_clear", bus.irq, 0);
    goto_cyc(100);
    chk("c100_qei", bus.qei_latch, 1);
    chk("c100_first_miss", bus.miss_count, 0);
    chk("c100_duty_old", bus.duty_a, 0);
    goto_cyc(101);
    chk("c101_update", bus.duty_update, 1);
    chk("c101_a", bus.duty_a, 500);
    chk("c101_b_clamp", bus.duty_b, 2000);
    chk("c101_c", bus.duty_c, 0);
    goto_cyc(102); chk("c102_update_pulse", bus.duty_update, 0);

    // commit landing exactly on a boundary with irq still pending
    goto_cyc(150); wr(2'd0, 12'd123);
    goto_cyc(200);
    chk("c200_qei", bus.qei_latch, 1);
    chk("c200_irq", bus.irq, 1);
    wr(2'd3, 12'd1);
    chk("c201_no_update", bus.duty_update, 0);
    chk("c201_miss", bus.miss_count, 1);
    chk("c201_a_hold", bus.duty_a, 500);
    goto_cyc(301);
    chk("c301_update", bus.duty_update, 1);
    chk("c301_a", bus.duty_a, 123);
    chk("c301_miss_clear", bus.miss_count, 0);

    // no more commits: misses accumulate into the fault
    goto_cyc(401); chk("c401_miss", bus.miss_count, 1);
    goto_cyc(501); chk("c501_miss", bus.miss_count, 2);
    chk("c501_fault", bus.fault, 0);
    goto_cyc(601);
    chk("c601_miss", bus.miss_count, 3);
    chk("c601_fault", bus.fault, 1);
    chk("c601_duty_zero", bus.duty_a, 0);
    goto_cyc(650);
    chk("c650_qei", bus.qei_latch, 0);
    chk("c650_irq", bus.irq, 0);
    bus.enable = 1'b0;
    goto_cyc(660); chk("c660_fault_hold", bus.fault, 1);
    bus.enable = 1'b1;
    goto_cyc(700);
    wr(2'd3, 12'd3);
    chk("clr_fault", bus.fault, 0);
    chk("clr_miss", bus.miss_count, 0);
    chk("clr_qei", bus.qei_latch, 1);
    cyc = 0;

    // disable drops duties; re-enable starts clean
    wr(2'd0, 12'd700); wr(2'd1, 12'd700); wr(2'd2, 12'd700);
    goto_cyc(20); wr(2'd3, 12'd1);
    goto_cyc(101);
    chk("en_update", bus.duty_update, 1);
    chk("en_a700", bus.duty_a, 700);
    goto_cyc(105); bus.enable = 1'b0;
    step();
    chk("dis_a_zero", bus.duty_a, 0);
    chk("dis_c_zero", bus.duty_c, 0);
    goto_cyc(110); bus.enable = 1'b1;
    step(); cyc = 0;
    chk("reen_qei", bus.qei_latch, 1);
    step();
    chk("reen_no_update", bus.duty_update, 0);
    chk("reen_no_miss", bus.miss_count, 0);

    // reset mid-period with a commit pending
    wr(2'd0, 12'd300);
    goto_cyc(5); wr(2'd3, 12'd1);
    goto_cyc(55);
    chk("pre_reset_irq", bus.irq, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_irq", bus.irq, 0);
    chk("mid_reset_qei", bus.qei_latch, 0);
    chk("mid_reset_duty", bus.duty_a, 0);
    step(); step();
    reset = 1'b0;
    upd_seen = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      upd_seen += int'(bus.duty_update);
    end
    chk("post_reset_no_update", upd_seen, 0);

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      bus.wr_en   = ($urandom_range(0, 19) == 0);
      bus.wr_addr = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: d = 12'd0;
        1: d = 12'd1999;
        2: d = 12'd2000;
        3: d = 12'd2001;
        4: d = 12'($urandom_range(0, 3));
        default: d = 12'($urandom_range(0, 4095));
      endcase
      bus.wr_data = d;
      if ($urandom_range(0, 399) == 0) bus.enable = ~bus.enable;
      step();
    end
    bus.wr_en = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
